mlp_layer_sequencer: RTL and testbench

- Controller that time-multiplexes one registered matmul datapath across the layers of an MLP.
- Accepts an input vector through a valid/ready handshake and drives the weight-bank select (layer_idx) and the matmul operand mux (src_sel).
- Ping-pongs layer results between two activation buffer banks, then presents the final bank to a valid/ready consumer.
- Sits between the host/stream interface and the matmul, its weight ROM banks and its activation buffers; it owns no data, only sequencing.

---
 rtl/mlp_layer_sequencer_if.sv | 43 ++++
 rtl/mlp_layer_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_layer_sequencer_if.sv
// Bundle of the control and handshake signals between the MLP layer sequencer
// and its surroundings (host stream, matmul operand mux, weight-bank select,
// activation buffer banks, result consumer).
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high. Each side drives its own flag
// independently. The sequencer never makes its ready or valid depend
// combinationally on the other side's flag.
//   input stream : in_valid (host)  / in_ready  (sequencer)
//   output stream: out_valid (seq.) / out_ready (consumer)
//
// master : the sequencer side (drives control outputs)
// slave  : the environment side (host, matmul glue, consumer)
interface mlp_layer_sequencer_if #(
  parameter int LAYER_W = 2
);
  logic               start;
  logic [LAYER_W-1:0] num_layers;
  logic               abort;
  logic               in_valid;
  logic               in_ready;
  logic [LAYER_W-1:0] layer_idx;
  logic               src_sel;
  logic               act_rd_bank;
  logic               act_wr_bank;
  logic               act_wr_en;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;

  modport master (
    input  start, num_layers, abort, in_valid, out_ready,
    output in_ready, layer_idx, src_sel, act_rd_bank, act_wr_bank,
           act_wr_en, out_valid, busy, done
  );

  modport slave (
    output start, num_layers, abort, in_valid, out_ready,
    input  in_ready, layer_idx, src_sel, act_rd_bank, act_wr_bank,
           act_wr_en, out_valid, busy, done
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// MLP layer sequencer: time-multiplexes one registered matmul across the
// layers of an MLP. It accepts an input vector, steps the weight-bank select
// and the operand mux layer by layer, and ping-pongs results between two
// activation banks. It then offers the final bank to a consumer. It holds no
// data, only sequencing state.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        control/handshake bundle (master side), see the interface file
//   state_dbg  current FSM state (0 IDLE, 1 ACCEPT, 2 WAIT, 3 CAPTURE, 4 EMIT)
//
// Every output is a flop whose next value is derived from the next state.
// There is therefore no combinational path from any input to any output.
module mlp_layer_sequencer #(
  parameter int MAX_LAYERS = 4,
  parameter int LAYER_W    = 2,
  parameter int MM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mlp_layer_sequencer_if.master bus,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACCEPT  = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_EMIT    = 3'd4;

  localparam int CNT_W = (MM_LATENCY > 1) ? $clog2(MM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(MM_LATENCY - 1);
  localparam logic [LAYER_W:0]   MAX_EXT  = (LAYER_W+1)'(MAX_LAYERS);
  localparam logic [LAYER_W-1:0] MAX_LAST = LAYER_W'(MAX_LAYERS - 1);

  logic [2:0]         state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [LAYER_W-1:0] last_q, last_d;     // index of the final layer (nl-1)
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // remaining WAIT cycles minus one
  logic               src_sel_q, src_sel_d;
  logic               rd_bank_q, rd_bank_d;
  logic               wr_bank_q, wr_bank_d;
  logic               in_ready_q, in_ready_d;
  logic               wr_en_q, wr_en_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Clamp the requested layer count to 1..MAX_LAYERS and keep it as a last
  // index. The compare is one bit wider because MAX_LAYERS can equal
  // 2**LAYER_W.
  logic [LAYER_W-1:0] nl_last;
  always_comb begin
    nl_last = '0;
    if (bus.num_layers == '0) begin
      nl_last = '0;
    end else if ({1'b0, bus.num_layers} >= MAX_EXT) begin
      nl_last = MAX_LAST;
    end else begin
      nl_last = bus.num_layers - 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    src_sel_d = src_sel_q;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          last_d    = nl_last;
          layer_d   = '0;
          src_sel_d = 1'b0;
          rd_bank_d = 1'b0;
          wr_bank_d = 1'b0;
          state_d   = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        // in_ready is high for the whole of ACCEPT, so in_valid alone
        // completes the handshake here.
        if (bus.in_valid) begin
          wr_bank_d = 1'b0;
          cnt_d     = CNT_LOAD;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CAPTURE: begin
        rd_bank_d = wr_bank_q;
        if (layer_q == last_q) begin
          state_d = ST_EMIT;
        end else begin
          // The next layer reads what was just written. It writes the other
          // bank, so read and write banks never collide.
          layer_d   = layer_q + 1'b1;
          src_sel_d = 1'b1;
          wr_bank_d = ~wr_bank_q;
          cnt_d     = CNT_LOAD;
          state_d   = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end

    // Back in IDLE every control output returns to zero.
    if (state_d == ST_IDLE) begin
      layer_d   = '0;
      src_sel_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_bank_d = 1'b0;
    end

    in_ready_d  = (state_d == ST_ACCEPT);
    wr_en_d     = (state_d == ST_CAPTURE);
    out_valid_d = (state_d == ST_EMIT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      layer_q     <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      src_sel_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_bank_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      src_sel_q   <= src_sel_d;
      rd_bank_q   <= rd_bank_d;
      wr_bank_q   <= wr_bank_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.layer_idx   = layer_q;
  assign bus.src_sel     = src_sel_q;
  assign bus.act_rd_bank = rd_bank_q;
  assign bus.act_wr_bank = wr_bank_q;
  assign bus.act_wr_en   = wr_en_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer. Two instances share one set of input
// drivers. dut_a has MM_LATENCY=1 and dut_b has MM_LATENCY=3. Only the
// instance selected by 'lane' sees start, and the observed outputs are muxed
// by 'lane'. LAYER_W=3 lets num_layers=7 be applied, with MAX_LAYERS=4.
// Inputs are driven 1 time unit after a rising edge. Outputs are monitored on
// the falling edge.
module tb_mlp_layer_sequencer;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACCEPT  = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_EMIT    = 3'd4;
  localparam logic [1:0] K_WR   = 2'd1;
  localparam logic [1:0] K_OUT  = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [2:0] num_layers = 3'd0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       lane = 1'b0;

  mlp_layer_sequencer_if #(.LAYER_W(3)) bus_a ();
  mlp_layer_sequencer_if #(.LAYER_W(3)) bus_b ();
  logic [2:0] state_a, state_b;

  assign bus_a.start      = start & ~lane;
  assign bus_a.num_layers = num_layers;
  assign bus_a.abort      = abort;
  assign bus_a.in_valid   = in_valid;
  assign bus_a.out_ready  = out_ready;
  assign bus_b.start      = start & lane;
  assign bus_b.num_layers = num_layers;
  assign bus_b.abort      = abort;
  assign bus_b.in_valid   = in_valid;
  assign bus_b.out_ready  = out_ready;

  mlp_layer_sequencer #(.MAX_LAYERS(4), .LAYER_W(3), .MM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .state_dbg(state_a)
  );
  mlp_layer_sequencer #(.MAX_LAYERS(4), .LAYER_W(3), .MM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .state_dbg(state_b)
  );

  logic [2:0] o_state, o_layer;
  logic o_in_ready, o_src, o_rd, o_wr, o_wr_en, o_out_valid, o_busy, o_done;
  assign o_state     = lane ? state_b           : state_a;
  assign o_layer     = lane ? bus_b.layer_idx   : bus_a.layer_idx;
  assign o_in_ready  = lane ? bus_b.in_ready    : bus_a.in_ready;
  assign o_src       = lane ? bus_b.src_sel     : bus_a.src_sel;
  assign o_rd        = lane ? bus_b.act_rd_bank : bus_a.act_rd_bank;
  assign o_wr        = lane ? bus_b.act_wr_bank : bus_a.act_wr_bank;
  assign o_wr_en     = lane ? bus_b.act_wr_en   : bus_a.act_wr_en;
  assign o_out_valid = lane ? bus_b.out_valid   : bus_a.out_valid;
  assign o_busy      = lane ? bus_b.busy        : bus_a.busy;
  assign o_done      = lane ? bus_b.done        : bus_a.done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int wr_pulses = 0;
  logic [W-1:0] exp_q[$];

  // Event word: {kind, cycles since input handshake, layer, src, rd, wr}
  function automatic logic [W-1:0] mk_ev(input logic [1:0] kind, input int rel,
                                         input int layer, input logic src,
                                         input logic rd, input logic wr);
    logic [7:0] r;
    logic [2:0] l;
    r = rel[7:0];
    l = layer[2:0];
    return {kind, r, l, src, rd, wr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_compare(input logic [W-1:0] act);
    logic [W-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_unexpected: got event %h, required no event (cycle %0d)", act, cyc);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_errors++;
        $display("FAIL sb_event: got %h, required %h (cycle %0d)", act, e, cyc);
      end
    end
  endtask

  // Cycle count, and the edge on which the input handshake happened.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_in_ready && in_valid) hs_cyc <= cyc + 1;
  end

  // Monitor: turns every write strobe, output handshake and done pulse into
  // an event and checks it against the scoreboard. The read bank is
  // irrelevant while the matmul reads the input vector, so it is recorded as
  // 0 then.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_wr_en) begin
        wr_pulses++;
        sb_compare(mk_ev(K_WR, cyc - hs_cyc, int'(o_layer), o_src,
                         o_src ? o_rd : 1'b0, o_wr));
      end
      if (o_out_valid && out_ready)
        sb_compare(mk_ev(K_OUT, cyc - hs_cyc, int'(o_layer), o_src, o_rd, o_wr));
      if (o_done)
        sb_compare(mk_ev(K_DONE, cyc - hs_cyc, 0, o_busy, o_out_valid, 1'b0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({o_in_ready, o_layer, o_src, o_rd, o_wr, o_wr_en, o_out_valid, o_busy, o_done});
  endfunction

  // One full run. nl is the clamped layer count the sequencer should use.
  task automatic do_run(input logic [2:0] nl_in, input int nl, input int acc_stall,
                        input int out_stall);
    int lat;
    int k;
    logic [2:0] h_layer;
    logic h_rd;
    lat = lane ? 3 : 1;
    for (int i = 0; i < nl; i++)
      exp_q.push_back(mk_ev(K_WR, i * (lat + 1) + lat, i, i > 0,
                            (i > 0) ? 1'((i - 1) % 2) : 1'b0, 1'(i % 2)));
    exp_q.push_back(mk_ev(K_OUT, nl * (lat + 1) + out_stall, nl - 1, nl > 1,
                          1'((nl - 1) % 2), 1'((nl - 1) % 2)));
    exp_q.push_back(mk_ev(K_DONE, nl * (lat + 1) + out_stall + 1, 0, 1'b0, 1'b0, 1'b0));
    wr_pulses = 0;
    out_ready = (out_stall == 0);
    start = 1'b1;
    num_layers = nl_in;
    tick();
    start = 1'b0;
    check("accept_entry", 32'({o_state, o_in_ready, o_busy}), 32'({ST_ACCEPT, 1'b1, 1'b1}));
    for (int s = 0; s < acc_stall; s++) begin
      tick();
      check("accept_hold", 32'({o_state, o_in_ready}), 32'({ST_ACCEPT, 1'b1}));
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("wait_layer0", 32'({o_state, o_layer, o_src, o_wr, o_in_ready}),
          32'({ST_WAIT, 3'd0, 1'b0, 1'b0, 1'b0}));
    k = 0;
    while (!o_out_valid && k < 200) begin
      tick();
      k++;
    end
    check("emit_reached", 32'(o_out_valid), 32'd1);
    h_layer = o_layer;
    h_rd = o_rd;
    for (int s = 0; s < out_stall; s++) begin
      check("emit_hold", 32'({o_state, o_out_valid, o_layer, o_rd, o_done}),
            32'({ST_EMIT, 1'b1, h_layer, h_rd, 1'b0}));
      start = (s == 3);
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    check("done_cycle", 32'({o_done, o_busy, o_state}), 32'({1'b1, 1'b0, ST_IDLE}));
    check("wr_pulse_count", 32'(wr_pulses), 32'(nl));
    out_ready = 1'b0;
    tick();
    check("done_one_cycle", 32'(o_done), 32'd0);
  endtask

  task automatic do_abort();
    int k;
    exp_q.push_back(mk_ev(K_WR, 1, 0, 1'b0, 1'b0, 1'b0));
    start = 1'b1;
    num_layers = 3'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!(o_state == ST_WAIT && o_layer == 3'd1) && k < 50) begin
      tick();
      k++;
    end
    check("abort_reach_wait1", 32'({o_state, o_layer, o_src, o_rd, o_wr}),
          32'({ST_WAIT, 3'd1, 1'b1, 1'b0, 1'b1}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", 32'(o_state), 32'(ST_IDLE));
    check("abort_outs_zero", all_outs(), 32'd0);
    repeat (6) tick();
    check("abort_stays_idle", 32'(o_state), 32'(ST_IDLE));
  endtask

  task automatic do_reset_mid_capture();
    int k;
    exp_q.push_back(mk_ev(K_WR, 1, 0, 1'b0, 1'b0, 1'b0));
    start = 1'b1;
    num_layers = 3'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!o_wr_en && k < 50) begin
      tick();
      k++;
    end
    check("rst_reach_capture", 32'(o_state), 32'(ST_CAPTURE));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_idle_now", 32'(o_state), 32'(ST_IDLE));
    check("rst_outs_zero", all_outs(), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tick();
    check("rst_stays_idle", 32'({o_state, all_outs()}), 32'({ST_IDLE, 32'd0}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(o_state), 32'(ST_IDLE));
    check("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    tick();
    check("post_reset_outs", all_outs(), 32'd0);

    // abort together with start keeps IDLE
    start = 1'b1;
    abort = 1'b1;
    num_layers = 3'd2;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_with_start", 32'({o_state, o_busy}), 32'({ST_IDLE, 1'b0}));

    do_run(3'd2, 2, 0, 0);   // two layers, consumer always ready
    do_run(3'd0, 1, 0, 0);   // zero requested runs one layer
    do_run(3'd7, 4, 0, 0);   // clamped to MAX_LAYERS
    do_run(3'd3, 3, 5, 10);  // input and output stalls
    do_abort();
    do_run(3'd1, 1, 0, 0);
    do_reset_mid_capture();
    do_run(3'd2, 2, 0, 0);

    lane = 1'b1;             // MM_LATENCY = 3 instance
    tick();
    do_run(3'd1, 1, 0, 0);

    repeat (4) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
